kb_scroll_banner: RTL
=====================

Name: kb_scroll_banner

Overview:
Parametrised successor to the fixed six-digit keyboard banner. It accepts PS/2 scan-code bytes from the receiver, decodes make/break/extended sequences, and stores hex characters in a DEPTH-entry circular buffer. It drives a DIGITS-wide multiplexed seven-segment display in one of two modes: a static view showing the newest characters, or an auto-scrolling marquee. Backspace, clear and scroll-toggle keys are handled.

Parameters:
DIGITS, 6, number of seven-segment digits (2..8)
DEPTH, 16, character buffer entries (power of 2, >= DIGITS)
SCROLL_DIV, 25_000_000, clk cycles per marquee step
REFRESH_DIV, 50_000, clk cycles each digit stays selected during scanning

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, reset is synchronous and active-high
scan_valid  in  1  one-cycle strobe: scan_code holds a received byte
scan_code  in  8  PS/2 scan-code byte
seg_out  out  8  {dp,g,f,e,d,c,b,a}, active-low; dp always 1
sel_out  out  DIGITS  one-hot active-low digit select; bit 0 = rightmost digit
scroll_en  out  1  1 = marquee mode
count  out  $clog2(DEPTH+1)  number of characters currently stored

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - decoder FSM to IDLE; wr_ptr=0, count=0; scroll_en=0; off=0
  - scroll and refresh counters to 0; scan index=0
  - sel_out={DIGITS-1{1},0}; seg_out=8'hFF
  - buffer contents are don't-care
- Decoder FSM, advances only on scan_valid:
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte -> execute as a make code, stay in IDLE.
  - BREAK: any byte is discarded -> IDLE.
  - EXT: F0 -> BREAK; any other byte is discarded (extended keys are ignored) -> IDLE.
- Make-code actions:
  - Hex keys append codes 0..F: 45,16,1E,26,25,2E,36,3D,3E,46,1C,32,21,23,24,2B.
  - Space (29) appends BLANK (5'h10).
  - Backspace (66): if count>0, wr_ptr-1 and count-1; else no effect.
  - Esc (76): count=0, wr_ptr=0.
  - Enter (5A): toggle scroll_en.
  - All other codes are ignored.
- Append:
  - buf[wr_ptr]<=code; wr_ptr<=wr_ptr+1 mod DEPTH.
  - count saturates at DEPTH. When full, the oldest character is overwritten.
- Edit latency: scan_valid sampled at edge n -> count, buffer and scroll_en updated at edge n+1.
- Static mode (scroll_en=0):
  - Digit i shows buf[wr_ptr-1-i mod DEPTH] if i<count, else BLANK.
  - The newest character is on the right.
- Scroll mode (scroll_en=1):
  - Stream S = stored characters oldest..newest followed by DIGITS BLANKs, length L=count+DIGITS.
  - Digit i shows S[(off+DIGITS-1-i) mod L].
  - off increments every SCROLL_DIV cycles and wraps from L-1 to 0.
  - If count=0, all digits are BLANK and off is held at 0.
- off and the scroll counter reset to 0 when:
  - scroll_en toggles, or
  - any append, backspace or clear takes effect.
  - If an edit and a scroll tick fall in the same cycle, the edit wins.
- Display scanning:
  - The scan index advances every REFRESH_DIV cycles and wraps from DIGITS-1 to 0.
  - sel_out and seg_out are registered: one cycle after the index or contents change.
  - BLANK maps to 8'hFF.
- Only one scan byte is processed per cycle. scan_valid held high for k cycles counts as k bytes.

Decomposition:
- Package banner_pkg holds:
  - BLANK code
  - scan-code constants (BREAK, EXT, BKSP, ESC, ENTER, SPACE)
  - function key_to_code (returns valid flag + 5-bit code)
  - function code_to_seg (5-bit code -> active-low segments)
- Sub-module banner_seg_mux holds:
  - refresh counter and scan index
  - per-digit code selection from a flattened DIGITS*5 code bus
  - code_to_seg and output registers
- The top contains the FSM, buffer, pointers, scroll logic and window generation.

Test Plan (DIGITS=4, DEPTH=8, SCROLL_DIV=4, REFRESH_DIV=2):
- Reset, then idle 20 cycles -> count=0, scroll_en=0, seg_out=FF on every digit; sel_out cycles E,D,B,7 every 2 cycles.
- Bytes 16,F0,16,1E,F0,1E -> count=2; digit0 seg A4 ("2"), digit1 F9 ("1"), digits 2-3 FF.
- Append 9 hex keys 1..9 -> count=8; digits 3..0 show 6,7,8,9; character 1 is lost. Backspace -> count=7; digit0 shows 8.
- Esc, then backspace -> count stays 0, no pointer underflow. Bytes E0,5A and E0,F0,5A -> scroll_en stays 0; F0,5A -> no change.
- Type 1,2 then 5A -> scroll_en=1, off=0; leftmost digit shows 1, then 2; off steps every 4 cycles and wraps 5->0 (L=6). Typing mid-scroll resets off to 0.
- Assert rst mid-scroll with count=3 -> at the next edge count=0, scroll_en=0, seg_out=FF, sel_out=E.

Source files
------------

// File: rtl/banner_pkg.sv
// Shared constants and lookup functions for the keyboard scroll banner:
// scan-code values, the internal 5-bit character code and its segment map.
package banner_pkg;
    localparam logic [4:0] BLANK    = 5'h10;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {DEC_IDLE, DEC_BREAK, DEC_EXT} dec_state_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] code;
    } key_t;

    // Keys that append a character: hex digits and space.
    function automatic key_t key_to_code(input logic [7:0] sc);
        key_t k;
        k.vld  = 1'b1;
        k.code = BLANK;
        case (sc)
            8'h45:    k.code = 5'h0;
            8'h16:    k.code = 5'h1;
            8'h1E:    k.code = 5'h2;
            8'h26:    k.code = 5'h3;
            8'h25:    k.code = 5'h4;
            8'h2E:    k.code = 5'h5;
            8'h36:    k.code = 5'h6;
            8'h3D:    k.code = 5'h7;
            8'h3E:    k.code = 5'h8;
            8'h46:    k.code = 5'h9;
            8'h1C:    k.code = 5'hA;
            8'h32:    k.code = 5'hB;
            8'h21:    k.code = 5'hC;
            8'h23:    k.code = 5'hD;
            8'h24:    k.code = 5'hE;
            8'h2B:    k.code = 5'hF;
            SC_SPACE: k.code = BLANK;
            default:  k.vld  = 1'b0;
        endcase
        return k;
    endfunction

    // Active-low {dp,g,f,e,d,c,b,a}; dp stays dark.
    function automatic logic [7:0] code_to_seg(input logic [4:0] c);
        logic [7:0] s;
        case (c)
            5'h0:    s = 8'hC0;
            5'h1:    s = 8'hF9;
            5'h2:    s = 8'hA4;
            5'h3:    s = 8'hB0;
            5'h4:    s = 8'h99;
            5'h5:    s = 8'h92;
            5'h6:    s = 8'h82;
            5'h7:    s = 8'hF8;
            5'h8:    s = 8'h80;
            5'h9:    s = 8'h90;
            5'hA:    s = 8'h88;
            5'hB:    s = 8'h83;
            5'hC:    s = 8'hC6;
            5'hD:    s = 8'hA1;
            5'hE:    s = 8'h86;
            5'hF:    s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/banner_seg_mux.sv
// Multiplexed seven-segment scanner: walks one digit at a time and registers
// the select and segment pattern for that digit.
module banner_seg_mux
    import banner_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int REFRESH_DIV = 50_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*5-1:0]   codes,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     sel_out
);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int IW = $clog2(DIGITS);

    logic [RW-1:0] ref_cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            sel_out <= ~DIGITS'(1);
            seg_out <= 8'hFF;
        end else begin
            if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            sel_out <= ~(DIGITS'(1) << idx);
            seg_out <= code_to_seg(codes[idx*5 +: 5]);
        end
    end
endmodule

// File: rtl/kb_scroll_banner.sv
// PS/2 keyboard banner: decodes scan codes into a circular character buffer
// and shows either the newest characters or a scrolling marquee.
module kb_scroll_banner
    import banner_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int DEPTH       = 16,
    parameter int SCROLL_DIV  = 25_000_000,
    parameter int REFRESH_DIV = 50_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scan_valid,
    input  logic [7:0]                   scan_code,
    output logic [7:0]                   seg_out,
    output logic [DIGITS-1:0]            sel_out,
    output logic                         scroll_en,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH + DIGITS + 1);
    localparam int SW = $clog2(SCROLL_DIV + 1);

    dec_state_t             state;
    logic                   scan_vld_q;
    logic [7:0]             scan_code_q;
    logic [DEPTH-1:0][4:0]  mem;
    logic [AW-1:0]          wr_ptr;
    logic [OW-1:0]          off;
    logic [OW-1:0]          len;
    logic [SW-1:0]          scroll_cnt;
    key_t                   key;
    logic                   make, do_app, do_bksp, do_clr, do_tog, edit;

    assign len = OW'(count) + OW'(DIGITS);

    always_comb begin
        key     = key_to_code(scan_code_q);
        make    = scan_vld_q && (state == DEC_IDLE) &&
                  (scan_code_q != SC_BREAK) && (scan_code_q != SC_EXT);
        do_app  = make && key.vld;
        do_bksp = make && (scan_code_q == SC_BKSP) && (count != '0);
        do_clr  = make && (scan_code_q == SC_ESC);
        do_tog  = make && (scan_code_q == SC_ENTER);
        edit    = do_app || do_bksp || do_clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DEC_IDLE;
            scan_vld_q  <= 1'b0;
            scan_code_q <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            scroll_en   <= 1'b0;
            off         <= '0;
            scroll_cnt  <= '0;
        end else begin
            // Input byte is registered, so edits land one edge after capture.
            scan_vld_q  <= scan_valid;
            scan_code_q <= scan_code;
            if (scan_vld_q) begin
                case (state)
                    DEC_IDLE:  state <= (scan_code_q == SC_BREAK) ? DEC_BREAK :
                                        (scan_code_q == SC_EXT)   ? DEC_EXT : DEC_IDLE;
                    DEC_EXT:   state <= (scan_code_q == SC_BREAK) ? DEC_BREAK : DEC_IDLE;
                    default:   state <= DEC_IDLE;
                endcase
            end
            if (do_app) begin
                mem[wr_ptr] <= key.code;
                wr_ptr      <= wr_ptr + 1'b1;
                if (count != CW'(DEPTH)) count <= count + 1'b1;
            end
            if (do_bksp) begin
                wr_ptr <= wr_ptr - 1'b1;
                count  <= count - 1'b1;
            end
            if (do_clr) begin
                wr_ptr <= '0;
                count  <= '0;
            end
            if (do_tog) scroll_en <= ~scroll_en;

            if (edit || do_tog || !scroll_en || count == '0) begin
                off        <= '0;
                scroll_cnt <= '0;
            end else if (scroll_cnt == SW'(SCROLL_DIV - 1)) begin
                scroll_cnt <= '0;
                off        <= (off == len - 1'b1) ? '0 : off + 1'b1;
            end else begin
                scroll_cnt <= scroll_cnt + 1'b1;
            end
        end
    end

    // Window: static shows newest-right; marquee indexes the stream
    // oldest..newest followed by DIGITS blanks.
    logic [DIGITS*5-1:0] codes;
    logic [OW:0]         pos;
    logic [AW-1:0]       addr;

    always_comb begin
        codes = '0;
        pos   = '0;
        addr  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!scroll_en) begin
                addr = wr_ptr - AW'(i) - 1'b1;
                codes[i*5 +: 5] = (CW'(i) < count) ? mem[addr] : BLANK;
            end else begin
                pos = {1'b0, off} + (OW+1)'(DIGITS - 1 - i);
                if (pos >= {1'b0, len}) pos = pos - {1'b0, len};
                addr = wr_ptr - AW'(count) + AW'(pos);
                codes[i*5 +: 5] = (pos < (OW+1)'(count)) ? mem[addr] : BLANK;
            end
        end
    end

    banner_seg_mux #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_seg_mux (
        .clk     (clk),
        .rst     (rst),
        .codes   (codes),
        .seg_out (seg_out),
        .sel_out (sel_out)
    );
endmodule
